ex_mdu: RTL and testbench

EX_MDU -- requirements
Module: ex_mdu

---
 rtl/ex_mdu.sv | 182 ++++++++++++++++++
 tb/tb_ex_mdu.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/ex_mdu.sv
// EX-stage multiply/divide unit with the HI/LO registers. It runs a 32-step
// radix-2 iteration on operand magnitudes, then applies a sign fix-up step.
module ex_mdu (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_start,
  input  logic [1:0]  i_op,
  input  logic [31:0] i_rs,
  input  logic [31:0] i_rt,
  input  logic        i_hi_we,
  input  logic        i_lo_we,
  input  logic [31:0] i_wdata,
  input  logic        i_flush,
  output logic [31:0] o_hi,
  output logic [31:0] o_lo,
  output logic        o_busy,
  output logic        o_done
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_FIX  = 2'd2;

  localparam logic [5:0] LAST_ITER = 6'd31;

  logic [1:0]  state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic        is_div_q, is_div_d;
  logic        neg_lo_q, neg_lo_d;   // product sign, or quotient sign
  logic        neg_hi_q, neg_hi_d;   // remainder sign (dividend sign)
  logic        div0_q, div0_d;
  logic [31:0] b_q, b_d;             // multiplicand or divisor magnitude
  logic [63:0] acc_q, acc_d;         // {partial product} or {remainder, quotient}
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic        done_q, done_d;

  // Operand decode for the start cycle.
  logic        op_div, op_signed;
  logic        rs_neg, rt_neg;
  logic [31:0] rs_mag, rt_mag;

  always_comb begin
    op_div    = i_op[1];
    op_signed = i_op[0];
    rs_neg    = op_signed & i_rs[31];
    rt_neg    = op_signed & i_rt[31];
    // The magnitude of 0x80000000 wraps to itself, which is its correct
    // unsigned value.
    rs_mag    = rs_neg ? (32'd0 - i_rs) : i_rs;
    rt_mag    = rt_neg ? (32'd0 - i_rt) : i_rt;
  end

  // One shift-add multiply step: add the multiplicand on the LSB, then shift
  // the 65-bit {carry, acc} right by one.
  logic [32:0] mul_sum;
  logic [63:0] mul_next;

  always_comb begin
    mul_sum  = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, b_q} : 33'd0);
    mul_next = {mul_sum, acc_q[31:1]};
  end

  // One restoring divide step. The shifted partial remainder can be 33 bits
  // wide; after a successful subtract it is below the divisor, so 32 bits hold it.
  logic [32:0] div_rem;
  logic        div_ok;
  logic [31:0] div_sub;
  logic [63:0] div_next;

  always_comb begin
    div_rem  = {acc_q[63:32], acc_q[31]};
    div_ok   = (div_rem >= {1'b0, b_q});
    div_sub  = div_rem[31:0] - b_q;
    div_next = {div_ok ? div_sub : div_rem[31:0], acc_q[30:0], div_ok};
  end

  // Sign correction applied in FIX.
  logic [63:0] prod_fix;
  logic [31:0] quo_fix, rem_fix;

  always_comb begin
    prod_fix = neg_lo_q ? (64'd0 - acc_q) : acc_q;
    quo_fix  = div0_q ? 32'hFFFF_FFFF
                      : (neg_lo_q ? (32'd0 - acc_q[31:0]) : acc_q[31:0]);
    rem_fix  = neg_hi_q ? (32'd0 - acc_q[63:32]) : acc_q[63:32];
  end

  always_comb begin
    // NOTE: every *_d gets its hold value first, so a branch that skips an
    // assignment cannot infer a latch.
    state_d  = state_q;
    cnt_d    = cnt_q;
    is_div_d = is_div_q;
    neg_lo_d = neg_lo_q;
    neg_hi_d = neg_hi_q;
    div0_d   = div0_q;
    b_d      = b_q;
    acc_d    = acc_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;

    if (i_flush) begin
      // Abort wins over start, MTHI/MTLO and FIX completion alike.
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (i_start) begin
            is_div_d = op_div;
            neg_lo_d = rs_neg ^ rt_neg;
            neg_hi_d = rs_neg;
            div0_d   = op_div && (i_rt == 32'd0);
            b_d      = op_div ? rt_mag : rs_mag;
            acc_d    = {32'd0, op_div ? rs_mag : rt_mag};
            cnt_d    = 6'd0;
            state_d  = ST_CALC;
          end else begin
            if (i_hi_we) hi_d = i_wdata;
            if (i_lo_we) lo_d = i_wdata;
          end
        end
        ST_CALC: begin
          acc_d = is_div_q ? div_next : mul_next;
          cnt_d = cnt_q + 6'd1;
          if (cnt_q == LAST_ITER) state_d = ST_FIX;
        end
        ST_FIX: begin
          if (is_div_q) begin
            hi_d = rem_fix;
            lo_d = quo_fix;
          end else begin
            hi_d = prod_fix[63:32];
            lo_d = prod_fix[31:0];
          end
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // NOTE: the datapath registers are reset along with the control state so
  // that no X from an unreset operand can ever reach HI/LO.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= 6'd0;
      is_div_q <= 1'b0;
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
      div0_q   <= 1'b0;
      b_q      <= 32'd0;
      acc_q    <= 64'd0;
      hi_q     <= 32'd0;
      lo_q     <= 32'd0;
      done_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every flop sampling the
      // pre-edge values regardless of statement order.
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      is_div_q <= is_div_d;
      neg_lo_q <= neg_lo_d;
      neg_hi_q <= neg_hi_d;
      div0_q   <= div0_d;
      b_q      <= b_d;
      acc_q    <= acc_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      done_q   <= done_d;
    end
  end

  assign o_hi   = hi_q;
  assign o_lo   = lo_q;
  assign o_busy = (state_q != ST_IDLE);
  assign o_done = done_q;

endmodule

// File: tb/tb_ex_mdu.sv
// Self-checking bench for ex_mdu: a table of operations run through a result
// scoreboard, plus hand-written flush, busy-start and mid-operation reset sequences.
module tb_ex_mdu;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_start = 1'b0;
  logic [1:0]  i_op = 2'b00;
  logic [31:0] i_rs = '0;
  logic [31:0] i_rt = '0;
  logic        i_hi_we = 1'b0;
  logic        i_lo_we = 1'b0;
  logic [31:0] i_wdata = '0;
  logic        i_flush = 1'b0;
  logic [31:0] o_hi, o_lo;
  logic        o_busy, o_done;

  always #5 clk = ~clk;

  ex_mdu dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_start (i_start),
    .i_op    (i_op),
    .i_rs    (i_rs),
    .i_rt    (i_rt),
    .i_hi_we (i_hi_we),
    .i_lo_we (i_lo_we),
    .i_wdata (i_wdata),
    .i_flush (i_flush),
    .o_hi    (o_hi),
    .o_lo    (o_lo),
    .o_busy  (o_busy),
    .o_done  (o_done)
  );

  localparam logic [1:0] MULTU = 2'b00, MULT = 2'b01, DIVU = 2'b10, DIV = 2'b11;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] rs, rt, hi, lo;
  } vec_t;

  typedef struct {
    logic [31:0] hi, lo;
  } exp_t;

  vec_t vecs [11];
  exp_t sb [$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic write_hilo(input logic hi_we, input logic lo_we, input logic [31:0] data);
    @(negedge clk);
    i_hi_we = hi_we;
    i_lo_we = lo_we;
    i_wdata = data;
    @(negedge clk);
    i_hi_we = 1'b0;
    i_lo_we = 1'b0;
  endtask

  // Start one operation, expect it in the scoreboard, then watch o_busy until
  // o_done. disturb_at >= 1 issues a new i_start plus an MTLO at that iteration.
  task automatic run_op(input string name, input logic [1:0] op, input logic [31:0] rs,
                        input logic [31:0] rt, input logic [31:0] hi, input logic [31:0] lo,
                        input int disturb_at);
    int   busy_n;
    logic got;
    exp_t e;
    @(negedge clk);
    i_start = 1'b1;
    i_op    = op;
    i_rs    = rs;
    i_rt    = rt;
    sb.push_back('{hi: hi, lo: lo});
    @(negedge clk);
    i_start = 1'b0;
    i_rs    = $urandom;
    i_rt    = $urandom;
    busy_n  = 0;
    got     = 1'b0;
    for (int k = 0; k < 40 && !got; k++) begin
      if (o_done) begin
        got = 1'b1;
      end else begin
        if (o_busy) busy_n++;
        if (busy_n == disturb_at) begin
          i_start = 1'b1;
          i_op    = ~op;
          i_lo_we = 1'b1;
          i_wdata = 32'hDEAD_BEEF;
        end else begin
          i_start = 1'b0;
          i_lo_we = 1'b0;
        end
        @(negedge clk);
      end
    end
    i_start = 1'b0;
    i_lo_we = 1'b0;
    check({name, ".done_seen"}, {63'd0, got}, 64'd1);
    check({name, ".busy_cycles"}, 64'(busy_n), 64'd33);
    e = sb.pop_front();
    if (got) begin
      check({name, ".hi"}, {32'd0, o_hi}, {32'd0, e.hi});
      check({name, ".lo"}, {32'd0, o_lo}, {32'd0, e.lo});
      check({name, ".idle_at_done"}, {63'd0, o_busy}, 64'd0);
      @(negedge clk);
      check({name, ".done_pulse"}, {63'd0, o_done}, 64'd0);
    end
  endtask

  initial begin
    int   busy_n;
    logic done_seen;

    vecs[0]  = '{MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
    vecs[1]  = '{MULT,  32'hFFFF_FFFD, 32'd5,         32'hFFFF_FFFF, 32'hFFFF_FFF1};
    vecs[2]  = '{DIV,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD};
    vecs[3]  = '{DIVU,  32'h1234_5678, 32'd0,         32'h1234_5678, 32'hFFFF_FFFF};
    vecs[4]  = '{DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
    vecs[5]  = '{DIVU,  32'd100,       32'd7,         32'd2,         32'd14};
    vecs[6]  = '{MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
    vecs[7]  = '{DIV,   32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD};
    vecs[8]  = '{MULTU, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 32'h0000_0000};
    vecs[9]  = '{DIV,   32'hFFFF_FFF8, 32'd0,         32'hFFFF_FFF8, 32'hFFFF_FFFF};
    vecs[10] = '{MULT,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001};

    // Reset state.
    repeat (3) @(negedge clk);
    check("reset.outputs", {o_hi, o_lo}, 64'd0);
    check("reset.ctrl", {62'd0, o_busy, o_done}, 64'd0);
    rst_n = 1'b1;

    // MTHI / MTLO in IDLE.
    write_hilo(1'b1, 1'b0, 32'h1111_2222);
    check("mthi", {32'd0, o_hi}, 64'h1111_2222);
    write_hilo(1'b0, 1'b1, 32'h3333_4444);
    check("mtlo", {32'd0, o_lo}, 64'h3333_4444);

    for (int i = 0; i < 11; i++)
      run_op($sformatf("v%0d", i), vecs[i].op, vecs[i].rs, vecs[i].rt,
             vecs[i].hi, vecs[i].lo, -1);

    // New start and MTLO while busy are both ignored.
    run_op("busy_start", MULT, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 5);

    // Flush at iteration 10: back to IDLE, HI/LO untouched, no o_done.
    write_hilo(1'b1, 1'b0, 32'hAAAA_0000);
    write_hilo(1'b0, 1'b1, 32'h0000_5555);
    @(negedge clk);
    i_start = 1'b1;
    i_op    = MULTU;
    i_rs    = 32'd3;
    i_rt    = 32'd4;
    @(negedge clk);
    i_start   = 1'b0;
    busy_n    = 0;
    done_seen = 1'b0;
    for (int k = 0; k < 40 && busy_n < 10; k++) begin
      if (o_busy) busy_n++;
      done_seen |= o_done;
      if (busy_n < 10) @(negedge clk);
    end
    i_flush = 1'b1;
    @(negedge clk);
    i_flush = 1'b0;
    check("flush.busy", {63'd0, o_busy}, 64'd0);
    check("flush.hilo", {o_hi, o_lo}, {32'hAAAA_0000, 32'h0000_5555});
    for (int k = 0; k < 40; k++) begin
      done_seen |= o_done;
      @(negedge clk);
    end
    check("flush.no_done", {63'd0, done_seen}, 64'd0);
    check("flush.hilo_later", {o_hi, o_lo}, {32'hAAAA_0000, 32'h0000_5555});

    // Asynchronous reset at iteration 20.
    @(negedge clk);
    i_start = 1'b1;
    i_op    = MULTU;
    i_rs    = 32'hFFFF_FFFF;
    i_rt    = 32'd3;
    @(negedge clk);
    i_start = 1'b0;
    busy_n  = 0;
    for (int k = 0; k < 40 && busy_n < 20; k++) begin
      if (o_busy) busy_n++;
      if (busy_n < 20) @(negedge clk);
    end
    check("pre_reset.busy", {63'd0, o_busy}, 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("async_reset.hilo", {o_hi, o_lo}, 64'd0);
    check("async_reset.ctrl", {62'd0, o_busy, o_done}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op("post_reset", MULTU, 32'd7, 32'd6, 32'd0, 32'd42, -1);

    check("scoreboard.empty", 64'(sb.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
